// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_pkg
// Description : Shared types, latency limits and byte-enable merge helper for
//               the dual-port byte-enabled SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } sram_state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int MERGE_W    = 512;
  localparam int MERGE_BE_W = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] be_merge(
    input logic [MERGE_W-1:0]    old_word,
    input logic [MERGE_W-1:0]    new_word,
    input logic [MERGE_BE_W-1:0] be
  );
    logic [MERGE_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MERGE_BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_init_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_init_ctrl
// Description : Post-reset zero-fill sweep: owns the INIT/RUN state machine
//               and the sweep address counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_init_ctrl
  import sram_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_init_we,
  output logic [ADDR_W-1:0] o_init_addr,
  output logic              o_init_busy
);

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

  sram_state_t       r_state;
  sram_state_t       w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_init_we   = 1'b0;
    case (r_state)
      S_INIT: begin
        o_init_we = 1'b1;
        if (r_cnt == c_last_addr) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_INIT;
    endcase
  end

  assign o_init_addr = r_cnt;
  assign o_init_busy = (r_state == S_INIT);

endmodule
`default_nettype wire

// File: rtl/sram_dp_be.sv
`default_nettype none
// ============================================================================
// Module      : sram_dp_be
// Description : Single-clock SRAM with separate write/read ports, byte
//               enables, 1- or 2-cycle read latency, selectable collision
//               policy, range checking and a post-reset zero-fill sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_dp_be
  import sram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int RD_LAT = 1,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_wr_en,
  input  logic [ADDR_W-1:0]   i_wr_addr,
  input  logic [DATA_W-1:0]   i_wr_data,
  input  logic [DATA_W/8-1:0] i_wr_be,
  input  logic                i_rd_en,
  input  logic [ADDR_W-1:0]   i_rd_addr,
  output logic [DATA_W-1:0]   o_rd_data,
  output logic                o_rd_valid,
  output logic                o_init_busy,
  output logic                o_addr_err
);

  localparam logic [ADDR_W:0] c_depth_lim = (ADDR_W + 1)'(DEPTH);

  generate
    if (DATA_W % 8 != 0) begin : g_bad_data_w
      $error("sram_dp_be: DATA_W must be a multiple of 8");
    end
    if (DATA_W > MERGE_W) begin : g_bad_merge_w
      $error("sram_dp_be: DATA_W exceeds be_merge width");
    end
    if ((RD_LAT < RD_LAT_MIN) || (RD_LAT > RD_LAT_MAX)) begin : g_bad_rd_lat
      $error("sram_dp_be: RD_LAT must be 1 or 2");
    end
  endgenerate

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_init_we;
  logic [ADDR_W-1:0] w_init_addr;
  logic              w_init_busy;

  sram_init_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_init_ctrl (
    .clk         (clk),
    .rst         (rst),
    .o_init_we   (w_init_we),
    .o_init_addr (w_init_addr),
    .o_init_busy (w_init_busy)
  );

  logic w_run;
  logic w_wr_in_rng;
  logic w_rd_in_rng;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_err;

  assign w_run       = ~w_init_busy;
  assign w_wr_in_rng = ({1'b0, i_wr_addr} < c_depth_lim);
  assign w_rd_in_rng = ({1'b0, i_rd_addr} < c_depth_lim);
  assign w_wr_acc    = w_run & i_wr_en & w_wr_in_rng;
  assign w_rd_acc    = w_run & i_rd_en;
  assign w_err       = w_run & ((i_wr_en & ~w_wr_in_rng) | (i_rd_en & ~w_rd_in_rng));

  logic [DATA_W-1:0] w_wr_merged;

  assign w_wr_merged = DATA_W'(be_merge(MERGE_W'(r_mem[i_wr_addr]),
                                        MERGE_W'(i_wr_data),
                                        MERGE_BE_W'(i_wr_be)));

  // The sweep owns the write port until it finishes.
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = i_wr_addr;
    w_mem_wdata = w_wr_merged;
    if (w_init_we) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = w_init_addr;
      w_mem_wdata = '0;
    end else if (w_wr_acc) begin
      w_mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  logic [DATA_W-1:0] w_rd_word;

  always_comb begin
    w_rd_word = '0;
    if (w_rd_in_rng) begin
      if ((BYPASS != 0) && w_wr_acc && (i_wr_addr == i_rd_addr)) begin
        w_rd_word = w_wr_merged;
      end else begin
        w_rd_word = r_mem[i_rd_addr];
      end
    end
  end

  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_data;
  logic              r_addr_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_s1_valid <= w_rd_acc;
      r_addr_err <= w_err;
      if (w_rd_acc) r_s1_data <= w_rd_word;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              r_s2_valid;
      logic [DATA_W-1:0] r_s2_data;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_s2_valid <= 1'b0;
          r_s2_data  <= '0;
        end else begin
          r_s2_valid <= r_s1_valid;
          if (r_s1_valid) r_s2_data <= r_s1_data;
        end
      end

      assign o_rd_valid = r_s2_valid;
      assign o_rd_data  = r_s2_data;
    end else begin : g_lat1
      assign o_rd_valid = r_s1_valid;
      assign o_rd_data  = r_s1_data;
    end
  endgenerate

  assign o_init_busy = w_init_busy;
  assign o_addr_err  = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_sram_dp_be.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_dp_be
// Description : Scoreboard bench driving two sram_dp_be instances from shared
//               stimulus: A (16 deep, latency 1, write-first) and
//               B (12 deep, latency 2, read-first).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_dp_be;
  import sram_pkg::*;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_wr_en = 1'b0;
  logic [3:0]  i_wr_addr = '0;
  logic [31:0] i_wr_data = '0;
  logic [3:0]  i_wr_be = '0;
  logic        i_rd_en = 1'b0;
  logic [3:0]  i_rd_addr = '0;

  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b;
  logic        busy_a, busy_b;
  logic        err_a, err_b;

  int dep[2] = '{16, 12};
  int lat[2] = '{1, 2};
  int byp[2] = '{1, 0};

  logic [31:0] mdl[2][16];
  exp_t        sb_q[2][$];
  int          err_q[2][$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_dp_be #(.DATA_W(32), .DEPTH(16), .RD_LAT(1), .BYPASS(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .i_wr_be(i_wr_be),
    .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr),
    .o_rd_data(rd_data_a), .o_rd_valid(rd_valid_a), .o_init_busy(busy_a), .o_addr_err(err_a)
  );

  sram_dp_be #(.DATA_W(32), .DEPTH(12), .RD_LAT(2), .BYPASS(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .i_wr_be(i_wr_be),
    .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr),
    .o_rd_data(rd_data_b), .o_rd_valid(rd_valid_b), .o_init_busy(busy_b), .o_addr_err(err_b)
  );

  // Scoreboard: pops one expected read per rd_valid and checks addr_err each cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        logic        v, e, e_exp;
        logic [31:0] dat;
        exp_t        x;
        v   = (d == 0) ? rd_valid_a : rd_valid_b;
        e   = (d == 0) ? err_a : err_b;
        dat = (d == 0) ? rd_data_a : rd_data_b;
        if (v === 1'b1) begin
          checks++;
          if (sb_q[d].size() == 0) begin
            failures++;
            $display("FAIL rd_valid_unexpected dut%0d cyc=%0d got data=%h required no rd_valid", d, cyc, dat);
          end else begin
            x = sb_q[d].pop_front();
            if (dat !== x.data || cyc != x.due) begin
              failures++;
              $display("FAIL rd_data dut%0d got %h at cyc %0d required %h at cyc %0d", d, dat, cyc, x.data, x.due);
            end
          end
        end else if (v !== 1'b0) begin
          checks++;
          failures++;
          $display("FAIL rd_valid_x dut%0d cyc=%0d got %b required 0/1", d, cyc, v);
        end
        while (sb_q[d].size() > 0 && sb_q[d][0].due < cyc) begin
          checks++;
          failures++;
          $display("FAIL rd_valid_missing dut%0d cyc=%0d required data %h at cyc %0d", d, cyc, sb_q[d][0].data, sb_q[d][0].due);
          void'(sb_q[d].pop_front());
        end
        e_exp = (err_q[d].size() > 0 && err_q[d][0] == cyc);
        if (e_exp) void'(err_q[d].pop_front());
        checks++;
        if (e !== e_exp) begin
          failures++;
          $display("FAIL addr_err dut%0d cyc=%0d got %b required %b", d, cyc, e, e_exp);
        end
      end
    end
  end

  task automatic issue(input bit we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input bit re, input logic [3:0] ra);
    @(negedge clk);
    i_wr_en = we; i_wr_addr = wa; i_wr_data = wd; i_wr_be = be;
    i_rd_en = re; i_rd_addr = ra;
    for (int d = 0; d < 2; d++) begin
      bit          wok, rok;
      logic [31:0] rdv, mrg;
      exp_t        x;
      wok = we && (int'(wa) < dep[d]);
      rok = re && (int'(ra) < dep[d]);
      mrg = 32'(be_merge(MERGE_W'(mdl[d][wa]), MERGE_W'(wd), MERGE_BE_W'(be)));
      if (re) begin
        rdv = 32'h0;
        if (rok) rdv = (byp[d] != 0 && wok && wa == ra) ? mrg : mdl[d][ra];
        x.data = rdv;
        x.due  = cyc + lat[d];
        sb_q[d].push_back(x);
      end
      if ((we && !wok) || (re && !rok)) err_q[d].push_back(cyc + 1);
      if (wok) mdl[d][wa] = mrg;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_wr_en = 1'b0;
      i_rd_en = 1'b0;
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 16; a++) mdl[d][a] = 32'h0;
  endtask

  // Call at the negedge where rst has just been dropped; counts busy samples.
  task automatic count_sweep(input string tag);
    int n_a, n_b;
    n_a = 0; n_b = 0;
    for (int k = 0; k < 40; k++) begin
      if (k != 0) @(negedge clk);
      if (busy_a === 1'b1) n_a++;
      if (busy_b === 1'b1) n_b++;
      if (busy_b !== 1'b1) begin
        i_wr_en = 1'b0;
        i_rd_en = 1'b0;
      end
    end
    checks++;
    if (n_a != 16) begin
      failures++;
      $display("FAIL %s_busy_cycles dut0 got %0d required 16", tag, n_a);
    end
    checks++;
    if (n_b != 12) begin
      failures++;
      $display("FAIL %s_busy_cycles dut1 got %0d required 12", tag, n_b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks += 8;
    if (rd_data_a !== 32'h0) begin failures++; $display("FAIL reset_rd_data dut0 got %h required 0", rd_data_a); end
    if (rd_data_b !== 32'h0) begin failures++; $display("FAIL reset_rd_data dut1 got %h required 0", rd_data_b); end
    if (rd_valid_a !== 1'b0) begin failures++; $display("FAIL reset_rd_valid dut0 got %b required 0", rd_valid_a); end
    if (rd_valid_b !== 1'b0) begin failures++; $display("FAIL reset_rd_valid dut1 got %b required 0", rd_valid_b); end
    if (err_a !== 1'b0) begin failures++; $display("FAIL reset_addr_err dut0 got %b required 0", err_a); end
    if (err_b !== 1'b0) begin failures++; $display("FAIL reset_addr_err dut1 got %b required 0", err_b); end
    if (busy_a !== 1'b1) begin failures++; $display("FAIL reset_init_busy dut0 got %b required 1", busy_a); end
    if (busy_b !== 1'b1) begin failures++; $display("FAIL reset_init_busy dut1 got %b required 1", busy_b); end
    mon_en = 1'b1;
  endtask

  task automatic test_init_sweep();
    @(negedge clk);
    rst = 1'b0;
    // Requests held during the sweep must be ignored.
    i_wr_en = 1'b1; i_wr_addr = 4'd0; i_wr_data = 32'hFFFF_FFFF; i_wr_be = 4'hF;
    i_rd_en = 1'b1; i_rd_addr = 4'd0;
    count_sweep("init");
    clear_model();
    for (int a = 0; a < 16; a++) issue(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(a));
    idle(4);
  endtask

  task automatic test_byte_enables();
    issue(1'b1, 4'd3, 32'hAABB_CCDD, 4'hF, 1'b0, 4'd0);
    issue(1'b1, 4'd3, 32'h1122_3344, 4'h5, 1'b0, 4'd0);
    issue(1'b1, 4'd3, 32'h5555_5555, 4'h0, 1'b0, 4'd0);
    issue(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3);
    idle(4);
    checks += 2;
    if (rd_data_a !== 32'hAA22_CC44) begin failures++; $display("FAIL byte_enable dut0 got %h required aa22cc44", rd_data_a); end
    if (rd_data_b !== 32'hAA22_CC44) begin failures++; $display("FAIL byte_enable dut1 got %h required aa22cc44", rd_data_b); end
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 4; a++) issue(1'b1, 4'(a), 32'(a + 1), 4'hF, 1'b0, 4'd0);
    for (int a = 0; a < 4; a++) issue(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(a));
    idle(4);
    checks += 2;
    if (rd_data_a !== 32'd4) begin failures++; $display("FAIL b2b_last dut0 got %h required 4", rd_data_a); end
    if (rd_data_b !== 32'd4) begin failures++; $display("FAIL b2b_last dut1 got %h required 4", rd_data_b); end
  endtask

  task automatic test_collision();
    issue(1'b1, 4'd5, 32'hFFFF_FFFF, 4'h3, 1'b1, 4'd5);
    idle(4);
    checks += 2;
    if (rd_data_a !== 32'h0000_FFFF) begin failures++; $display("FAIL collision_bypass dut0 got %h required 0000ffff", rd_data_a); end
    if (rd_data_b !== 32'h0) begin failures++; $display("FAIL collision_old dut1 got %h required 0", rd_data_b); end
    issue(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd5);
    idle(4);
  endtask

  task automatic test_range();
    issue(1'b1, 4'd13, 32'hDEAD_BEEF, 4'hF, 1'b0, 4'd0);
    issue(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd13);
    issue(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd12);
    issue(1'b1, 4'd14, 32'h1234_5678, 4'hF, 1'b1, 4'd15);
    issue(1'b1, 4'd11, 32'hCAFE_F00D, 4'hF, 1'b0, 4'd0);
    issue(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd11);
    idle(4);
    checks += 2;
    if (rd_data_a !== 32'hCAFE_F00D) begin failures++; $display("FAIL range_last_addr dut0 got %h required cafef00d", rd_data_a); end
    if (rd_data_b !== 32'hCAFE_F00D) begin failures++; $display("FAIL range_last_addr dut1 got %h required cafef00d", rd_data_b); end
  endtask

  task automatic test_reset_mid_read();
    issue(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd1);
    @(negedge clk);
    rst = 1'b1;
    i_rd_en = 1'b0;
    sb_q[1].delete();
    @(negedge clk);
    checks += 3;
    if (rd_valid_b !== 1'b0) begin failures++; $display("FAIL midrst_rd_valid dut1 got %b required 0", rd_valid_b); end
    if (busy_a !== 1'b1) begin failures++; $display("FAIL midrst_busy dut0 got %b required 1", busy_a); end
    if (busy_b !== 1'b1) begin failures++; $display("FAIL midrst_busy dut1 got %b required 1", busy_b); end
    rst = 1'b0;
    count_sweep("midrst");
    clear_model();
    issue(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3);
    idle(4);
    checks += 2;
    if (rd_data_a !== 32'h0) begin failures++; $display("FAIL midrst_cleared dut0 got %h required 0", rd_data_a); end
    if (rd_data_b !== 32'h0) begin failures++; $display("FAIL midrst_cleared dut1 got %h required 0", rd_data_b); end
  endtask

  task automatic test_drain();
    idle(6);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (sb_q[d].size() != 0 || err_q[d].size() != 0) begin
        failures++;
        $display("FAIL drain dut%0d got %0d reads/%0d errs pending required 0", d, sb_q[d].size(), err_q[d].size());
      end
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_init_sweep();
    test_byte_enables();
    test_back_to_back();
    test_collision();
    test_range();
    test_reset_mid_read();
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got no completion required finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
